// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Sequential adder/subtractor. It processes WIDTH-bit operands CHUNK bits per
//   clock and ripples the inter-chunk carry through a register. Operands come in
//   over a valid/ready handshake and results leave over another one. In subtract
//   mode the block computes a + ~b + 1.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/sub valid
//   in_ready   out  1      block can accept operands (registered)
//   a, b       in   WIDTH  operands
//   sub        in   1      0: a+b, 1: a-b
//   out_valid  out  1      sum/cout/ovf valid (registered)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One chunk of the ripple: {carry_out, chunk_sum} = x + y + cin.
  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             cin
  );
    add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // operand A, shifted down one chunk per CALC cycle
  logic [WIDTH-1:0] b_q, b_d;        // effective operand B (inverted for sub), shifted likewise
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;    // partial result; chunks enter at the top and shift down
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK:0]   chunk_add_s;
  logic [WIDTH-1:0] res_next_s;

  // Next-state, datapath and output-register logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    // The low chunk of the shifted operands is always the chunk currently being added.
    chunk_add_s = add_chunk(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry_q);
    // After NCHUNK shifts the first chunk has reached bit 0, giving the full sum in place.
    res_next_s  = (WIDTH'(chunk_add_s[CHUNK-1:0]) << (WIDTH - CHUNK)) | (res_q >> CHUNK);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub;
          idx_d      = '0;
          res_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_CALC: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_add_s[CHUNK];
        res_d   = res_next_s;
        if (idx_q == LAST_IDX) begin
          // Final chunk: a_q/b_q low chunk holds the original MSBs, so the sign
          // test for overflow can be taken directly from this chunk.
          idx_d       = '0;
          sum_d       = res_next_s;
          cout_d      = chunk_add_s[CHUNK];
          ovf_d       = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                        (chunk_add_s[CHUNK-1] != a_q[CHUNK-1]);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
